vend_controller: RTL

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_if.sv | 30 +++
 rtl/vend_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/vend_if.sv
// Coin-slot, dispenser and status signals of the vending controller.
interface vend_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic [1:0]          coin_a;
  logic                coin_a_vld;
  logic                coin_a_acc;
  logic [1:0]          coin_b;
  logic                coin_b_vld;
  logic                coin_b_acc;
  logic                cancel;
  logic                disp_req;
  logic                disp_ack;
  logic                chg_nkl;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  // Controller side
  modport master (
    input  coin_a, coin_a_vld, coin_b, coin_b_vld, cancel, disp_ack,
    output coin_a_acc, coin_b_acc, disp_req, chg_nkl, coin_rej, credit, busy
  );

  // Coin slots / dispenser side
  modport slave (
    output coin_a, coin_a_vld, coin_b, coin_b_vld, cancel, disp_ack,
    input  coin_a_acc, coin_b_acc, disp_req, chg_nkl, coin_rej, credit, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Two-slot vending controller: round-robin coin intake, vend handshake, nickel change.
// Optional macro VEND_CHANGE_EN enables the CHANGE state (refund / change return).
module vend_controller #(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic   clk,
  input  logic   rst,
  vend_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [1:0]          COIN_BAD = 2'b11;

  state_t              state_q, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic                rr_b_q, rr_b_nxt;
  logic                disp_req_q, disp_req_nxt;
  logic                grant_a, grant_b, rej;
  logic                cancel_hit;
  logic [1:0]          coin_sel;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] rem;

`ifdef VEND_CHANGE_EN
  logic chg_nkl_q, chg_nkl_nxt;
  assign cancel_hit = bus.cancel && (state_q == COLLECT);
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel;
  assign cancel_hit    = 1'b0;
`endif

  // Next-state, credit and coin-grant decode
  always_comb begin
    state_nxt    = state_q;
    credit_nxt   = credit_q;
    rr_b_nxt     = rr_b_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    rej          = 1'b0;
    coin_sel     = 2'b00;
    sum          = '0;
    rem          = '0;

    case (state_q)
      IDLE, COLLECT: begin
        if (cancel_hit) begin
          state_nxt = (credit_q == '0) ? IDLE : CHANGE;
        end else begin
          if (bus.coin_a_vld && (!bus.coin_b_vld || !rr_b_q)) begin
            grant_a = 1'b1;
          end else if (bus.coin_b_vld) begin
            grant_b = 1'b1;
          end
          coin_sel = grant_a ? bus.coin_a : bus.coin_b;
          if (grant_a || grant_b) begin
            rr_b_nxt = grant_a;
            if (coin_sel == COIN_BAD) begin
              rej = 1'b1;
            end else if (coin_sel != 2'b00) begin
              // Price range keeps credit + 2 below 2^CREDIT_W
              sum        = credit_q + CREDIT_W'(coin_sel);
              credit_nxt = sum;
              state_nxt  = (sum >= PRICE_C) ? VEND : COLLECT;
            end
          end
        end
      end

      VEND: begin
        if (bus.disp_ack && disp_req_q) begin
          rem        = credit_q - PRICE_C;
          credit_nxt = rem;
          if (rem == '0) begin
            state_nxt = IDLE;
          end else begin
`ifdef VEND_CHANGE_EN
            state_nxt = CHANGE;
`else
            state_nxt = (rem >= PRICE_C) ? VEND : COLLECT;
`endif
          end
        end
      end

`ifdef VEND_CHANGE_EN
      CHANGE: begin
        // One nickel leaves per cycle while chg_nkl is high
        if (credit_q <= CREDIT_W'(1)) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          credit_nxt = credit_q - CREDIT_W'(1);
        end
      end
`endif

      default: begin
        state_nxt  = IDLE;
        credit_nxt = '0;
      end
    endcase

    disp_req_nxt = (state_nxt == VEND);
`ifdef VEND_CHANGE_EN
    chg_nkl_nxt  = (state_nxt == CHANGE);
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      rr_b_q     <= 1'b0;
      disp_req_q <= 1'b0;
`ifdef VEND_CHANGE_EN
      chg_nkl_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      credit_q   <= credit_nxt;
      rr_b_q     <= rr_b_nxt;
      disp_req_q <= disp_req_nxt;
`ifdef VEND_CHANGE_EN
      chg_nkl_q  <= chg_nkl_nxt;
`endif
    end
  end

  // Consume strobes are combinational and forced low during reset
  assign bus.coin_a_acc = grant_a && rst;
  assign bus.coin_b_acc = grant_b && rst;
  assign bus.coin_rej   = rej && rst;
  assign bus.disp_req   = disp_req_q;
  assign bus.credit     = credit_q;
  assign bus.busy       = (state_q == VEND) || (state_q == CHANGE);
`ifdef VEND_CHANGE_EN
  assign bus.chg_nkl    = chg_nkl_q;
`else
  assign bus.chg_nkl    = 1'b0;
`endif

endmodule
